tmr_reg_scrubber: RTL

TMR_REG_SCRUBBER -- requirements
Module: tmr_reg_scrubber

---
 rtl/tmr_pkg.sv | 16 +
 rtl/tmr_word_voter.sv | 21 ++
 rtl/tmr_reg_scrubber.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-modular-redundant register scrubber.
package tmr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } tmr_state_e;

    localparam logic [1:0] NONE = 2'd3;

    // True when at least two of the three flags are set.
    function automatic logic maj3(input logic [2:0] f);
        return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
    endfunction

endpackage

// File: rtl/tmr_word_voter.sv
// Bitwise 2-of-3 majority over a word; VoterType picks the gate structure only.
module tmr_word_voter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned VoterType = 2
) (
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic [DataWidth-1:0] c_i,
    output logic [DataWidth-1:0] y_o
);

    // All three forms compute the same majority function.
    if (VoterType == 0) begin : g_classic
        assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end else if (VoterType == 1) begin : g_kp
        assign y_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end else begin : g_bn
        assign y_o = ((a_i ^ b_i) & c_i) | (~(a_i ^ b_i) & a_i);
    end

endmodule

// File: rtl/tmr_reg_scrubber.sv
// Triplicated register with majority read-out, fault detection, one-cycle scrub,
// fault injection and a saturating scrub counter.
module tmr_reg_scrubber
    import tmr_pkg::*;
#(
    parameter int unsigned          DataWidth  = 32,
    parameter logic [DataWidth-1:0] ResetValue = '0,
    parameter int unsigned          CntWidth   = 8,
    parameter int unsigned          VoterType  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 inj_valid_i,
    input  logic [1:0]           inj_copy_i,
    input  logic [DataWidth-1:0] inj_mask_i,
    output logic                 mismatch_o,
    output logic [2:0]           fault_copy_o,
    output logic                 multi_fault_o,
    output logic                 err_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    input  logic                 err_clr_i
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    (* keep = "true" *) logic [DataWidth-1:0] copy0_q;
    (* keep = "true" *) logic [DataWidth-1:0] copy1_q;
    (* keep = "true" *) logic [DataWidth-1:0] copy2_q;
    logic [DataWidth-1:0] copy0_d, copy1_d, copy2_d;
    logic [DataWidth-1:0] voted_s;
    tmr_state_e           state_q, state_d;
    logic [2:0]           fault_q, fault_d;
    logic                 err_q, err_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 mismatch_s;
    logic                 capture_s;

    tmr_word_voter #(
        .DataWidth (DataWidth),
        .VoterType (VoterType)
    ) u_voter (
        .a_i (copy0_q),
        .b_i (copy1_q),
        .c_i (copy2_q),
        .y_o (voted_s)
    );

    assign mismatch_s = (copy0_q != voted_s) || (copy1_q != voted_s) || (copy2_q != voted_s);

    // Next-state: write / detect / scrub, then injection, then counter clear.
    always_comb begin
        state_d   = state_q;
        copy0_d   = copy0_q;
        copy1_d   = copy1_q;
        copy2_d   = copy2_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        capture_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    copy0_d = data_i;
                    copy1_d = data_i;
                    copy2_d = data_i;
                end else if (mismatch_s) begin
                    state_d   = SCRUB;
                    capture_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SCRUB: begin
                copy0_d = voted_s;
                copy1_d = voted_s;
                copy2_d = voted_s;
                err_d   = 1'b1;
                state_d = IDLE;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inj_valid_i) begin
            case (inj_copy_i)
                2'd0:    copy0_d = copy0_d ^ inj_mask_i;
                2'd1:    copy1_d = copy1_d ^ inj_mask_i;
                2'd2:    copy2_d = copy2_d ^ inj_mask_i;
                NONE:    copy0_d = copy0_d;
                default: copy0_d = copy0_d;
            endcase
        end else begin
            copy0_d = copy0_d;
        end

        // Same-edge injections are folded in so back-to-back faults report together.
        if (capture_s) begin
            fault_d = {copy2_d != voted_s, copy1_d != voted_s, copy0_d != voted_s};
        end else begin
            fault_d = fault_q;
        end

        if (err_clr_i) begin
            cnt_d = {CntWidth{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, copy and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            copy0_q <= ResetValue;
            copy1_q <= ResetValue;
            copy2_q <= ResetValue;
            fault_q <= 3'b000;
            err_q   <= 1'b0;
            cnt_q   <= {CntWidth{1'b0}};
        end else begin
            state_q <= state_d;
            copy0_q <= copy0_d;
            copy1_q <= copy1_d;
            copy2_q <= copy2_d;
            fault_q <= fault_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o        = voted_s;
    assign ready_o       = (state_q == IDLE);
    assign mismatch_o    = (state_q == SCRUB);
    assign fault_copy_o  = fault_q;
    assign err_o         = err_q;
    assign multi_fault_o = err_q & maj3(fault_q);
    assign err_cnt_o     = cnt_q;

endmodule
